// File: rtl/pixel_stream_fifo.sv
// pixel_stream_fifo: single-clock parametrised pixel buffer between a pixel
// source and the channel-unpacking/display stage. Channel 0 sits in the MSBs.
// Provides fill level, almost-full/almost-empty thresholds and sticky
// overflow/underflow flags.
// Build option: define PIXEL_FIFO_FWFT_EN for first-word fall-through output.
// Without it, dout is a registered read with 1-clock latency.
module pixel_stream_fifo #(
    parameter int CH_W      = 8,
    parameter int CH_NUM    = 3,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [CH_NUM*CH_W-1:0]     din,
    input  logic                       rd_en,
    input  logic                       clr_err,
    output logic [CH_NUM*CH_W-1:0]     dout,
    output logic                       dout_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PW = CH_NUM * CH_W;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);
    localparam logic [LW-1:0] AE_L    = LW'(AE_THRESH);

    logic [PW-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          full_q, empty_q, af_q, ae_q;
    logic          ovf_q, ovf_d, udf_q, udf_d;
    logic          wr_acc, rd_acc;

    // Acceptance uses the registered full/empty from before the edge, so a
    // simultaneous read+write at full or empty only accepts one side.
    always_comb begin
        wr_acc   = wr_en && !full_q;
        rd_acc   = rd_en && !empty_q;
        wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (wr_acc && !rd_acc) begin
            level_d = level_q + LW'(1);
        end else if (rd_acc && !wr_acc) begin
            level_d = level_q - LW'(1);
        end
        // a new error event in the same cycle as clr_err keeps the flag set
        ovf_d = (ovf_q && !clr_err) || (wr_en && full_q);
        udf_d = (udf_q && !clr_err) || (rd_en && empty_q);
    end

    // Pointers, level, status (from the post-edge level) and sticky flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= (level_d == DEPTH_L);
            empty_q  <= (level_d == '0);
            af_q     <= (level_d >= AF_L);
            ae_q     <= (level_d <= AE_L);
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Pixel storage; deliberately not reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

`ifdef PIXEL_FIFO_FWFT_EN
    // Head entry is always on dout; zero whenever nothing is stored.
    always_comb begin
        dout       = '0;
        dout_valid = !empty_q;
        if (!empty_q) begin
            dout = mem_q[rd_ptr_q];
        end
    end
`else
    logic [PW-1:0] dout_q;
    logic          dout_valid_q;

    // Registered read: capture the head on an accepted read, hold otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_valid_q <= rd_acc;
            if (rd_acc) begin
                dout_q <= mem_q[rd_ptr_q];
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
`endif

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign level        = level_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_pixel_stream_fifo.sv
// Self-checking bench for pixel_stream_fifo (registered read mode build).
// A queue-based model tracks contents, flags and the registered output.
module tb_pixel_stream_fifo;

    localparam int DEPTH = 16;
    localparam int W     = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en, rd_en, clr_err;
    logic [W-1:0]  din, dout;
    logic          dout_valid, full, empty, almost_full, almost_empty;
    logic [4:0]    level;
    logic          overflow, underflow;

    // second, wide configuration
    logic          wr2, rd2, clr2;
    logic [39:0]   din2, dout2;
    logic          dv2, full2, empty2, af2, ae2, ovf2, udf2;
    logic [6:0]    level2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pixel_stream_fifo dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .clr_err(clr_err), .dout(dout), .dout_valid(dout_valid), .full(full),
        .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .level(level), .overflow(overflow), .underflow(underflow)
    );

    pixel_stream_fifo #(.CH_W(10), .CH_NUM(4), .DEPTH(64), .AF_THRESH(60), .AE_THRESH(2)) dut2 (
        .clk(clk), .rst(rst), .wr_en(wr2), .din(din2), .rd_en(rd2),
        .clr_err(clr2), .dout(dout2), .dout_valid(dv2), .full(full2),
        .empty(empty2), .almost_full(af2), .almost_empty(ae2),
        .level(level2), .overflow(ovf2), .underflow(udf2)
    );

    // reference model state
    logic [W-1:0] mq[$];
    logic [W-1:0] m_dout;
    logic         m_dv, m_ovf, m_udf;

    typedef struct {
        bit           wr, rd, clr;
        logic [W-1:0] d;
        int           lvl;
        bit           ovf, udf, dv;
        logic [W-1:0] q;
    } vec_t;
    vec_t tv[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_dout = '0;
        m_dv   = 1'b0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    task automatic model_step(input bit w, input bit r, input bit c, input logic [W-1:0] d);
        bit f, e;
        f = (mq.size() == DEPTH);
        e = (mq.size() == 0);
        m_ovf = (m_ovf && !c) || (w && f);
        m_udf = (m_udf && !c) || (r && e);
        m_dv  = r && !e;
        if (r && !e) m_dout = mq.pop_front();
        if (w && !f) mq.push_back(d);
    endtask

    task automatic check_model(input string tag);
        int n;
        n = mq.size();
        chk({tag, ".level"}, 64'(level), 64'(n));
        chk({tag, ".full"}, 64'(full), 64'(n == DEPTH));
        chk({tag, ".empty"}, 64'(empty), 64'(n == 0));
        chk({tag, ".almost_full"}, 64'(almost_full), 64'(n >= 14));
        chk({tag, ".almost_empty"}, 64'(almost_empty), 64'(n <= 2));
        chk({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
        chk({tag, ".underflow"}, 64'(underflow), 64'(m_udf));
        chk({tag, ".dout_valid"}, 64'(dout_valid), 64'(m_dv));
        chk({tag, ".dout"}, 64'(dout), 64'(m_dout));
    endtask

    task automatic cyc(input bit w, input bit r, input bit c, input logic [W-1:0] d, input string tag);
        wr_en = w; rd_en = r; clr_err = c; din = d;
        @(posedge clk);
        model_step(w, r, c, d);
        #1;
        check_model(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [39:0] word2;

        tv[0] = '{0, 1, 0, 24'h0,      0, 0, 1, 0, 24'h0};
        tv[1] = '{0, 0, 1, 24'h0,      0, 0, 0, 0, 24'h0};
        tv[2] = '{1, 0, 0, 24'h111111, 1, 0, 0, 0, 24'h0};
        tv[3] = '{1, 0, 0, 24'h222222, 2, 0, 0, 0, 24'h0};
        tv[4] = '{1, 1, 0, 24'h333333, 2, 0, 0, 1, 24'h111111};
        tv[5] = '{0, 1, 0, 24'h0,      1, 0, 0, 1, 24'h222222};
        tv[6] = '{0, 1, 0, 24'h0,      0, 0, 0, 1, 24'h333333};
        tv[7] = '{0, 1, 0, 24'h0,      0, 0, 1, 0, 24'h333333};
        tv[8] = '{0, 1, 1, 24'h0,      0, 0, 1, 0, 24'h333333};
        tv[9] = '{0, 0, 1, 24'h0,      0, 0, 0, 0, 24'h333333};

        wr2 = 0; rd2 = 0; clr2 = 0; din2 = '0;

        // reset held 3 cycles with traffic toggling
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            wr_en = i[0]; rd_en = !i[0]; clr_err = 0; din = 24'hC0FFEE;
            @(posedge clk); #1;
            check_model("reset");
        end
        rst = 1'b1;

        // table-driven basic sequence
        for (int i = 0; i < 10; i++) begin
            cyc(tv[i].wr, tv[i].rd, tv[i].clr, tv[i].d, "tbl_model");
            chk($sformatf("tbl[%0d].level", i), 64'(level), 64'(tv[i].lvl));
            chk($sformatf("tbl[%0d].overflow", i), 64'(overflow), 64'(tv[i].ovf));
            chk($sformatf("tbl[%0d].underflow", i), 64'(underflow), 64'(tv[i].udf));
            chk($sformatf("tbl[%0d].dout_valid", i), 64'(dout_valid), 64'(tv[i].dv));
            chk($sformatf("tbl[%0d].dout", i), 64'(dout), 64'(tv[i].q));
        end

        // fill 1..16, overflow attempt, drain in order
        for (int i = 1; i <= 16; i++) begin
            cyc(1, 0, 0, 24'(i), "fill");
            if (i == 13) chk("af_below_14", 64'(almost_full), 64'd0);
            if (i == 14) chk("af_at_14", 64'(almost_full), 64'd1);
        end
        chk("full_after_16", 64'(full), 64'd1);
        cyc(1, 0, 0, 24'hABCDEF, "ovf");
        chk("ovf_level", 64'(level), 64'd16);
        chk("ovf_flag", 64'(overflow), 64'd1);
        for (int i = 1; i <= 16; i++) begin
            cyc(0, 1, 0, 24'h0, "drain");
            chk($sformatf("drain[%0d]", i), 64'(dout), 64'(i));
        end
        chk("empty_after_drain", 64'(empty), 64'd1);
        cyc(0, 1, 0, 24'h0, "udf");
        chk("udf_flag", 64'(underflow), 64'd1);
        chk("udf_dv", 64'(dout_valid), 64'd0);
        cyc(0, 0, 1, 24'h0, "clr");
        chk("clr_ovf", 64'(overflow), 64'd0);
        chk("clr_udf", 64'(underflow), 64'd0);

        // simultaneous traffic at level 8 with wrap-around
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 24'($urandom), "fill8");
        for (int i = 0; i < 40; i++) begin
            cyc(1, 1, 0, 24'($urandom), "both8");
            chk("both8_level", 64'(level), 64'd8);
        end

        // both at full: read accepted, write rejected
        while (mq.size() < DEPTH) cyc(1, 0, 0, 24'($urandom), "fill16");
        cyc(1, 1, 0, 24'h5A5A5A, "both_full");
        chk("both_full_level", 64'(level), 64'd15);
        chk("both_full_ovf", 64'(overflow), 64'd1);
        cyc(0, 0, 1, 24'h0, "clr2");

        // asynchronous reset at level 5
        while (mq.size() > 5) cyc(0, 1, 0, 24'h0, "to5");
        chk("pre_async_level", 64'(level), 64'd5);
        wr_en = 0; rd_en = 0; clr_err = 0;
        #2;
        rst = 1'b0;
        #1;
        chk("async_level", 64'(level), 64'd0);
        chk("async_empty", 64'(empty), 64'd1);
        chk("async_dv", 64'(dout_valid), 64'd0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        check_model("after_async");

        // randomized traffic in phases of different write/read bias
        for (int ph = 0; ph < 4; ph++) begin
            for (int i = 0; i < 600; i++) begin
                int wp;
                wp = (ph == 0) ? 80 : (ph == 1) ? 20 : 50;
                cyc(($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < (100 - wp + (ph == 3 ? 10 : 0))),
                    ($urandom_range(0, 99) < 5), 24'($urandom), "rand");
            end
        end

        // wide configuration: 4 x 10-bit channels, depth 64
        wr_en = 0; rd_en = 0; clr_err = 0;
        word2 = {10'h3FF, 10'h000, 10'h155, 10'h2AA};
        wr2 = 1; din2 = word2;
        @(posedge clk); #1;
        for (int i = 1; i < 20; i++) begin
            din2 = 40'(i);
            @(posedge clk); #1;
        end
        wr2 = 0;
        chk("wide_level20", 64'(level2), 64'd20);
        chk("wide_not_full", 64'(full2), 64'd0);
        rd2 = 1;
        @(posedge clk); #1;
        rd2 = 0;
        chk("wide_dout", 64'(dout2), 64'(word2));
        chk("wide_dv", 64'(dv2), 64'd1);
        chk("wide_level19", 64'(level2), 64'd19);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
